// File: rtl/ntt_result_drain.sv
// rtl/ntt_result_drain.sv - collects NTT row results by index, then drains them in ascending order
module ntt_result_drain #(
    parameter int N  = 64,
    parameter int DW = 64,
    parameter int IW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [IW-1:0] in_index,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_index,
    output logic          out_last,
    output logic          done,
    output logic          busy,
    output logic          dup_err,
    output logic          idx_err
);

    typedef enum logic {
        S_COLLECT,
        S_DRAIN
    } state_t;

    localparam int            N_M1   = N - 1;
    localparam logic [IW:0]   N_C    = N[IW:0];
    localparam logic [IW-1:0] LAST_C = N_M1[IW-1:0];

    state_t          state_q, state_d;
    logic [IW:0]     fill_count_q, fill_count_d;
    logic [N-1:0]    filled_q, filled_d;
    logic [IW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            done_q, done_d;
    logic            dup_err_q, dup_err_d;
    logic            idx_err_q, idx_err_d;
    logic            wr_en;
    logic [DW-1:0]   mem_q [N];

    always_comb begin
        state_d      = state_q;
        fill_count_d = fill_count_q;
        filled_d     = filled_q;
        rd_ptr_d     = rd_ptr_q;
        done_d       = 1'b0;
        dup_err_d    = dup_err_q;
        idx_err_d    = idx_err_q;
        wr_en        = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (in_valid) begin
                    if ({1'b0, in_index} >= N_C) begin
                        idx_err_d = 1'b1;
                    end else if (filled_q[in_index]) begin
                        // Rewrites keep the newest value but never count twice toward completion
                        wr_en     = 1'b1;
                        dup_err_d = 1'b1;
                    end else begin
                        wr_en              = 1'b1;
                        filled_d[in_index] = 1'b1;
                        fill_count_d       = fill_count_q + 1'b1;
                        if (fill_count_q + 1'b1 == N_C) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (rd_ptr_q == LAST_C) begin
                        state_d      = S_COLLECT;
                        rd_ptr_d     = '0;
                        fill_count_d = '0;
                        filled_d     = '0;
                        done_d       = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_COLLECT;
            fill_count_q <= '0;
            filled_q     <= '0;
            rd_ptr_q     <= '0;
            done_q       <= 1'b0;
            dup_err_q    <= 1'b0;
            idx_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_count_q <= fill_count_d;
            filled_q     <= filled_d;
            rd_ptr_q     <= rd_ptr_d;
            done_q       <= done_d;
            dup_err_q    <= dup_err_d;
            idx_err_q    <= idx_err_d;
        end
    end

    // Result buffer survives reset; only the fill bookkeeping is cleared
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[in_index] <= in_data;
        end
    end

    assign in_ready  = (state_q == S_COLLECT);
    assign out_valid = (state_q == S_DRAIN);
    assign busy      = (state_q == S_DRAIN);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_index = out_valid ? rd_ptr_q : '0;
    assign out_last  = out_valid && (rd_ptr_q == LAST_C);
    assign done      = done_q;
    assign dup_err   = dup_err_q;
    assign idx_err   = idx_err_q;

endmodule

// File: tb/tb_ntt_result_drain.sv
// tb/tb_ntt_result_drain.sv - scoreboard bench for ntt_result_drain
module tb_ntt_result_drain;

    localparam int N  = 64;
    localparam int DW = 64;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_index = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic          done;
    logic          busy;
    logic          dup_err;
    logic          idx_err;

    ntt_result_drain #(.N(N), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_index(in_index), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last),
        .done(done), .busy(busy), .dup_err(dup_err), .idx_err(idx_err)
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            miscompares = 0;
    int            done_seen = 0;
    int            beats = 0;
    logic          pending_done = 1'b0;
    logic [DW-1:0] model [N];
    logic [IW+DW-1:0] sb [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops one expectation per transferred beat
    initial begin
        logic [IW+DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pending_done = 1'b0;
                beats = 0;
            end else begin
                if (pending_done) begin
                    chk("done_pulse", 64'(done), 64'd1);
                    chk("in_ready_at_done", 64'(in_ready), 64'd1);
                    chk("beat_total", 64'(beats), 64'(N));
                    beats = 0;
                    done_seen++;
                    pending_done = 1'b0;
                end else if (done) begin
                    chk("spurious_done", 64'(done), 64'd0);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got index %0d expected no beat", out_index);
                    end else begin
                        e = sb.pop_front();
                        chk("out_index", 64'(out_index), 64'(e[IW+DW-1:DW]));
                        chk("out_data", out_data, e[DW-1:0]);
                        chk("out_last", 64'(out_last), 64'(e[IW+DW-1:DW] == IW'(N-1)));
                        beats++;
                        if (e[IW+DW-1:DW] == IW'(N-1)) pending_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wr(input int idx, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_index = IW'(idx);
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model[idx] = d;
    endtask

    task automatic push_all();
        for (int i = 0; i < N; i++) sb.push_back({IW'(i), model[i]});
    endtask

    task automatic wait_drain();
        int start;
        start = done_seen;
        for (int c = 0; c < 300 && done_seen == start; c++) @(posedge clk);
        #1;
        if (done_seen == start) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d done pulses expected %0d", done_seen, start + 1);
        end
    endtask

    task automatic wait_index(input int idx);
        for (int c = 0; c < 200 && !(out_valid && out_index == IW'(idx)); c++) begin
            @(posedge clk); #1;
        end
        chk("reach_index", 64'(out_index), 64'(idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_errs", 64'({dup_err, idx_err}), 64'd0);
        rst = 1'b1;

        // In-order fill, first out_valid one cycle after the final accept
        for (int i = 0; i < N; i++) begin
            wr(i, 64'h1000 + 64'(i));
            if (i == N - 2) chk("early_valid", 64'(out_valid), 64'd0);
        end
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        chk("latency_busy", 64'(busy), 64'd1);
        chk("drain_in_ready", 64'(in_ready), 64'd0);
        push_all();
        wait_drain();

        // Backpressure at index 10
        for (int i = 0; i < N; i++) wr(i, 64'h5000 + 64'(i));
        push_all();
        wait_index(10);
        out_ready = 1'b0;
        repeat (5) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_index", 64'(out_index), 64'd10);
            chk("stall_data", out_data, 64'h500a);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_drain();

        // Out-of-order fill with input held during drain
        for (int i = N - 1; i >= 0; i--) wr(i, 64'hA5A5_0000_0000_0000 | 64'(i));
        push_all();
        in_valid = 1'b1;
        in_index = IW'(3);
        in_data  = 64'hDEAD_BEEF;
        for (int c = 0; c < 100 && out_index < IW'(40); c++) begin
            chk("drain_blocks_input", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain();
        chk("ooo_dup_err", 64'(dup_err), 64'd0);
        chk("ooo_idx_err", 64'(idx_err), 64'd0);

        // Duplicate write to index 5
        wr(5, 64'h11);
        wr(5, 64'h22);
        for (int i = 0; i < N; i++) begin
            if (i != 5) wr(i, 64'h2000 + 64'(i));
            if (i == N - 2) begin
                chk("dup_no_early_drain", 64'(out_valid), 64'd0);
                chk("dup_err_set", 64'(dup_err), 64'd1);
            end
        end
        chk("dup_drain_start", 64'(out_valid), 64'd1);
        push_all();
        wait_drain();
        chk("dup_err_sticky", 64'(dup_err), 64'd1);
        chk("dup_idx_err", 64'(idx_err), 64'd0);

        // Reset mid-drain at index 20
        for (int i = 0; i < N; i++) wr(i, 64'h3000 + 64'(i));
        push_all();
        wait_index(20);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_dup_err", 64'(dup_err), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) wr(i, 64'h4000 + 64'(i));
        push_all();
        wait_drain();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
